sfu_acc_pipe: RTL and testbench
===============================

// Module: sfu_acc_pipe
// PURPOSE
//  Parametrised post-array special-function unit: drains COL-lane psum rows from the
//  output FIFO and runs an addressed pass over psum memory (LOAD, ACC or RELU mode).
//  Adds signed saturating accumulate, a start/busy/done job handshake, on-chip address
//  generation and a fixed read-compute-write pipeline with FIFO back-pressure stalls.
// PARAMETERS
//  COL      8   lanes per row
//  PSUM_BW  16  signed psum width per lane
//  ADDR_W   4   psum memory address width (depth 2**ADDR_W rows)
//  SAT      1   1: saturate ACC to signed PSUM_BW range; 0: two's-complement wrap
// PORTS
//  clk            in   1             clock, all flops rising edge
//  reset_n        in   1             asynchronous, active-low reset
//  start          in   1             job request, sampled only in IDLE
//  mode           in   2             00 NOP, 01 LOAD, 10 ACC, 11 RELU; latched at start
//  base_addr      in   ADDR_W        first psum row of the pass
//  len            in   ADDR_W+1      rows in the pass (0..2**ADDR_W)
//  busy           out  1             high from accepted start until done pulse inclusive
//  done           out  1             one-cycle pulse, last write retired
//  ofifo_out      in   COL*PSUM_BW   FIFO head row, lane i at [(i+1)*PSUM_BW-1 : i*PSUM_BW]
//  ofifo_valid    in   1             FIFO non-empty
//  ofifo_rd       out  1             pop FIFO head this cycle
//  psum_mem_rd    out  1             read strobe; data valid on psum_mem_dout next cycle
//  psum_mem_raddr out  ADDR_W        read address
//  psum_mem_dout  in   COL*PSUM_BW   read data (1-cycle latency)
//  psum_mem_wr    out  1             write strobe
//  psum_mem_waddr out  ADDR_W        write address
//  psum_mem_din   out  COL*PSUM_BW   write data
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, pipeline valids cleared; asserting reset_n low
//   mid-pass aborts it with no further rd/wr/pop and no done.
//  FSM: IDLE -start&&len!=0&&mode!=NOP-> RUN -last row issued-> DRAIN -pipe empty-> DONE -> IDLE.
//   start with len==0 or mode==NOP: IDLE->DONE directly (done 1 cycle later, no accesses).
//   start while busy is ignored.
//  Issue (RUN, stage 0): row k (0..len-1) addr = (base_addr+k) mod 2**ADDR_W (wraps).
//   LOAD/ACC: issue only when ofifo_valid; ofifo_rd = psum_mem_rd = 1 same cycle.
//   ofifo_valid low -> bubble, k holds. RELU: issue every cycle, ofifo_rd stays 0.
//   LOAD asserts ofifo_rd but not psum_mem_rd (memory not read).
//  Stage 1: captures FIFO row (registered at issue) with psum_mem_dout; per lane:
//   LOAD: din=fifo; ACC: din=sat(mem+fifo) computed at PSUM_BW+1 bits,
//   clamp to [-2**(PSUM_BW-1), 2**(PSUM_BW-1)-1] if SAT else truncate;
//   RELU: din = mem[MSB] ? 0 : mem (signed compare).
//  Stage 2: psum_mem_wr/waddr/din registered outputs. Issue->write latency 2 cycles.
//  Each address touched once per pass, so no RAW hazard; len==2**ADDR_W covers every row once.
//  Memory write and read of different addresses in one cycle are legal (dual-port).
//  done: 1 cycle after final psum_mem_wr; back-to-back job may start the cycle after done.
//  Full-throughput: len rows with ofifo_valid stuck high finish in len+3 cycles start->done.
// STRUCTURE
//  Package sfu_pkg: mode enum (NOP/LOAD/ACC/RELU), FSM state enum, lane-slice helper.
//  Sub-module sfu_lane (PSUM_BW, SAT): one lane's combinational LOAD/ACC/RELU datapath,
//   generated COL times; top owns FSM, address counter, pipeline valid/addr regs.
// TESTING
//  1 Reset: hold reset_n=0 -> all outputs 0; release, no activity until start.
//  2 ACC, base=2,len=3, mem rows={5,-3,7}, fifo lanes=+1 -> rows 2..4 = {6,-2,8}, done at cycle 6.
//  3 ACC saturation PSUM_BW=16: mem 32767 + fifo 5 -> 32767; mem -32768 + fifo -1 -> -32768;
//    SAT=0 -> -32764 and 32767.
//  4 RELU base=14,len=4 (ADDR_W=4): addrs 14,15,0,1 wrap; -9->0, 0->0, 12->12; ofifo_rd never 1.
//  5 Back-pressure LOAD len=4, ofifo_valid toggles 1010... -> exactly 4 pops, 4 writes in
//    order, no write without pop, done after last write.
//  6 Abort: reset_n low after 2nd issue -> no further wr, no done; restart job completes cleanly;
//    start with len=0 -> done next cycle, no rd/wr.

Source files
------------

// File: rtl/sfu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfu_pkg                                                                  |
// | Shared types for the special-function accumulate pipe: job mode codes,   |
// | control FSM states and the lane-slice offset helper.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sfu_pkg;

   typedef enum logic [1:0] {
      MODE_NOP  = 2'b00,
      MODE_LOAD = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_RELU = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Low bit of lane 'lane' inside a packed row of 'bw'-bit lanes.
   function automatic int lane_lo(input int lane, input int bw);
      return lane * bw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sfu_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfu_lane                                                                 |
// | One lane of the write-back datapath (combinational).                     |
// |   mode  in  job mode (LOAD / ACC / RELU)                                 |
// |   fifo  in  lane value popped from the output FIFO                       |
// |   mem   in  lane value read from psum memory                             |
// |   din   out lane value to write back                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sfu_lane
   import sfu_pkg::*;
#(
   parameter int PSUM_BW = 16,
   parameter int SAT     = 1
)(
   input  mode_e              mode,
   input  logic [PSUM_BW-1:0] fifo,
   input  logic [PSUM_BW-1:0] mem,
   output logic [PSUM_BW-1:0] din
);

   localparam logic [PSUM_BW-1:0] POS_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0] NEG_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

   logic [PSUM_BW:0]   sum;
   logic               ovf;
   logic [PSUM_BW-1:0] acc;

   // One guard bit: overflow shows up as disagreement between the top two bits,
   // and the guard bit alone tells the true sign of the result.
   assign sum = {mem[PSUM_BW-1], mem} + {fifo[PSUM_BW-1], fifo};
   assign ovf = sum[PSUM_BW] ^ sum[PSUM_BW-1];
   assign acc = ((SAT != 0) && ovf) ? (sum[PSUM_BW] ? NEG_MIN : POS_MAX)
                                    : sum[PSUM_BW-1:0];

   always_comb begin
      din = '0;
      case (mode)
         MODE_LOAD: din = fifo;
         MODE_ACC:  din = acc;
         MODE_RELU: din = mem[PSUM_BW-1] ? '0 : mem;
         default:   din = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sfu_acc_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfu_acc_pipe                                                             |
// | Post-array special-function unit. Runs one addressed pass over psum      |
// | memory per job in LOAD, ACC (saturating) or RELU mode through a          |
// | read / compute / write pipeline, stalling on an empty output FIFO.       |
// |   clk, reset_n           clock, async active-low reset                   |
// |   start, mode            job request and mode (latched in IDLE)          |
// |   base_addr, len         first row and row count of the pass             |
// |   busy, done             job status, done is a one-cycle pulse           |
// |   ofifo_out/valid/rd     output FIFO head row, non-empty flag, pop       |
// |   psum_mem_rd/raddr/dout read port, data one cycle after the strobe      |
// |   psum_mem_wr/waddr/din  registered write port                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sfu_acc_pipe
   import sfu_pkg::*;
#(
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ADDR_W  = 4,
   parameter int SAT     = 1
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [ADDR_W:0]          len,
   output logic                     busy,
   output logic                     done,
   input  logic [COL*PSUM_BW-1:0]   ofifo_out,
   input  logic                     ofifo_valid,
   output logic                     ofifo_rd,
   output logic                     psum_mem_rd,
   output logic [ADDR_W-1:0]        psum_mem_raddr,
   input  logic [COL*PSUM_BW-1:0]   psum_mem_dout,
   output logic                     psum_mem_wr,
   output logic [ADDR_W-1:0]        psum_mem_waddr,
   output logic [COL*PSUM_BW-1:0]   psum_mem_din
);

   localparam int                ROW_W    = COL * PSUM_BW;
   localparam logic [ADDR_W:0]   ONE_ROW  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state;
   mode_e             job_mode;
   mode_e             req_mode;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              issue;

   logic              s1_valid;
   logic [ADDR_W-1:0] s1_addr;
   logic [ROW_W-1:0]  s1_fifo;
   logic [ROW_W-1:0]  lane_din;

   assign req_mode = mode_e'(mode);

   // RELU never consumes FIFO data, so it issues every RUN cycle; the other
   // modes advance only when a FIFO row is available.
   assign issue          = (state == ST_RUN) && ((job_mode == MODE_RELU) || ofifo_valid);
   assign ofifo_rd       = issue && (job_mode != MODE_RELU);
   assign psum_mem_rd    = issue && (job_mode != MODE_LOAD);
   assign psum_mem_raddr = addr;

   // Control FSM and address generation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         job_mode  <= MODE_NOP;
         addr      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  job_mode  <= req_mode;
                  addr      <= base_addr;
                  remaining <= len;
                  if ((len != '0) && (req_mode != MODE_NOP)) begin
                     state <= ST_RUN;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (issue) begin
                  addr      <= addr + ONE_ADDR;
                  remaining <= remaining - ONE_ROW;
                  if (remaining == ONE_ROW) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Once stage 1 is empty the final write is on the port this
               // cycle, so done lands exactly one cycle after it.
               if (!s1_valid) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Stage 1 (FIFO row + memory read data) and stage 2 (write port).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid       <= 1'b0;
         s1_addr        <= '0;
         s1_fifo        <= '0;
         psum_mem_wr    <= 1'b0;
         psum_mem_waddr <= '0;
         psum_mem_din   <= '0;
      end else begin
         s1_valid    <= issue;
         psum_mem_wr <= s1_valid;
         if (issue) begin
            s1_addr <= addr;
            s1_fifo <= ofifo_out;
         end
         if (s1_valid) begin
            psum_mem_waddr <= s1_addr;
            psum_mem_din   <= lane_din;
         end
      end
   end

   for (genvar i = 0; i < COL; i++) begin : g_lane
      sfu_lane #(
         .PSUM_BW (PSUM_BW),
         .SAT     (SAT)
      ) u_lane (
         .mode (job_mode),
         .fifo (s1_fifo[lane_lo(i, PSUM_BW) +: PSUM_BW]),
         .mem  (psum_mem_dout[lane_lo(i, PSUM_BW) +: PSUM_BW]),
         .din  (lane_din[lane_lo(i, PSUM_BW) +: PSUM_BW])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_sfu_acc_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sfu_acc_pipe                                                          |
// | Self-checking bench for sfu_acc_pipe. A saturating and a wrapping        |
// | instance share stimulus; each has its own behavioural psum memory.       |
// | Expected write-backs are queued when a job is launched and popped as     |
// | the saturating instance writes.                                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sfu_acc_pipe;
   import sfu_pkg::*;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_W  = 4;
   localparam int DW      = COL * PSUM_BW;
   localparam int PMAX    = (1 << (PSUM_BW - 1)) - 1;
   localparam int PMIN    = -(1 << (PSUM_BW - 1));

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   len = '0;
   logic [DW-1:0]     ofifo_out = '0;
   logic              ofifo_valid = 1'b0;

   logic              busy, done, ofifo_rd, psum_mem_rd, psum_mem_wr;
   logic [ADDR_W-1:0] psum_mem_raddr, psum_mem_waddr;
   logic [DW-1:0]     psum_mem_din, dout;

   logic              busy_w, done_w, ofifo_rd_w, rd_w, wr_w;
   logic [ADDR_W-1:0] raddr_w, waddr_w;
   logic [DW-1:0]     din_w, doutw;

   logic [DW-1:0]     mem  [16];
   logic [DW-1:0]     memw [16];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [DW-1:0]     pl_data = '0;

   typedef struct { logic [ADDR_W-1:0] addr; logic [DW-1:0] data; } exp_t;
   exp_t          sb_q[$];
   logic [DW-1:0] fifo_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int done_cyc, pops, wrs, rds, last_wr, order_err, busy_err;

   always #5 clk = ~clk;

   sfu_acc_pipe #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W), .SAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .base_addr(base_addr), .len(len), .busy(busy), .done(done),
      .ofifo_out(ofifo_out), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
      .psum_mem_rd(psum_mem_rd), .psum_mem_raddr(psum_mem_raddr),
      .psum_mem_dout(dout), .psum_mem_wr(psum_mem_wr),
      .psum_mem_waddr(psum_mem_waddr), .psum_mem_din(psum_mem_din));

   sfu_acc_pipe #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W), .SAT(0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .base_addr(base_addr), .len(len), .busy(busy_w), .done(done_w),
      .ofifo_out(ofifo_out), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd_w),
      .psum_mem_rd(rd_w), .psum_mem_raddr(raddr_w),
      .psum_mem_dout(doutw), .psum_mem_wr(wr_w),
      .psum_mem_waddr(waddr_w), .psum_mem_din(din_w));

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr]  <= pl_data;
         memw[pl_addr] <= pl_data;
      end
      if (psum_mem_wr) mem[psum_mem_waddr] <= psum_mem_din;
      if (wr_w)        memw[waddr_w]       <= din_w;
      if (psum_mem_rd) dout  <= mem[psum_mem_raddr];
      if (rd_w)        doutw <= memw[raddr_w];
   end

   function automatic logic [DW-1:0] row_fill(input int v);
      logic [DW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
      return r;
   endfunction

   function automatic logic [DW-1:0] row_ramp(input int v, input int step);
      logic [DW-1:0] r;
      int            x;
      for (int i = 0; i < COL; i++) begin
         x = v + i * step;
         r[i*PSUM_BW +: PSUM_BW] = x[PSUM_BW-1:0];
      end
      return r;
   endfunction

   function automatic int lane_of(input logic [DW-1:0] r, input int i);
      logic [PSUM_BW-1:0] t;
      t = r[i*PSUM_BW +: PSUM_BW];
      return $signed(t);
   endfunction

   // Integer reference: exact sum, then clamp (or keep low bits).
   function automatic logic [DW-1:0] model_row(input logic [1:0] m, input logic [DW-1:0] mr,
                                               input logic [DW-1:0] fr, input bit sat);
      logic [DW-1:0] r;
      int            a, f, s;
      for (int i = 0; i < COL; i++) begin
         a = lane_of(mr, i);
         f = lane_of(fr, i);
         case (m)
            MODE_LOAD: s = f;
            MODE_ACC: begin
               s = a + f;
               if (sat && s > PMAX) s = PMAX;
               if (sat && s < PMIN) s = PMIN;
            end
            MODE_RELU: s = (a < 0) ? 0 : a;
            default:   s = 0;
         endcase
         r[i*PSUM_BW +: PSUM_BW] = s[PSUM_BW-1:0];
      end
      return r;
   endfunction

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic push_expected(input logic [1:0] m, input logic [ADDR_W-1:0] b, input int l);
      logic [ADDR_W-1:0] a;
      logic [DW-1:0]     fr;
      for (int k = 0; k < l; k++) begin
         a  = b + ADDR_W'(k);
         fr = (m == MODE_RELU) ? '0 : fifo_q[k];
         sb_q.push_back('{addr: a, data: model_row(m, mem[a], fr, 1'b1)});
      end
   endtask

   // Launches a job at cycle 0 and steps cycles until done or a 80-cycle bound.
   task automatic run_job(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W:0] l, input bit toggle);
      int   c;
      bit   pop_now;
      exp_t e;
      done_cyc = -1; pops = 0; wrs = 0; rds = 0; last_wr = -1; order_err = 0; busy_err = 0;
      start = 1'b1; mode = m; base_addr = b; len = l;
      c = 0;
      while (done_cyc < 0 && c < 80) begin
         ofifo_valid = (fifo_q.size() > 0) && (!toggle || (c % 2 == 1));
         ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
         @(negedge clk);
         pop_now = ofifo_rd;
         if (ofifo_rd)    pops++;
         if (psum_mem_rd) rds++;
         if ((c >= 1) != busy) busy_err++;
         if (psum_mem_wr) begin
            wrs++;
            last_wr = c;
            if (wrs > pops && m == MODE_LOAD) order_err++;
            n_checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_write: unexpected write addr=%0d data=%h", psum_mem_waddr, psum_mem_din);
            end else begin
               e = sb_q.pop_front();
               if (psum_mem_waddr !== e.addr || psum_mem_din !== e.data)
                  $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                           psum_mem_waddr, psum_mem_din, e.addr, e.data);
               else n_pass++;
            end
         end
         if (done) done_cyc = c;
         @(posedge clk); #1;
         start = 1'b0;
         if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
         c++;
      end
      ofifo_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic act;
      reset_n = 1'b0; start = 1'b1; mode = MODE_ACC; len = 5'd3;
      ofifo_valid = 1'b1; ofifo_out = row_fill(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, ofifo_rd, psum_mem_rd, psum_mem_wr, psum_mem_raddr, psum_mem_waddr} !== '0)
         $display("FAIL reset_ctrl: got %b expected all 0",
                  {busy, done, ofifo_rd, psum_mem_rd, psum_mem_wr, psum_mem_raddr, psum_mem_waddr});
      else n_pass++;
      n_checks++;
      if (psum_mem_din !== '0) $display("FAIL reset_din: got %h expected 0", psum_mem_din);
      else n_pass++;
      @(posedge clk); #1;
      start = 1'b0; reset_n = 1'b1;
      act = 1'b0;
      repeat (4) begin
         @(negedge clk);
         act = act | busy | done | ofifo_rd | psum_mem_rd | psum_mem_wr;
      end
      n_checks++;
      if (act !== 1'b0) $display("FAIL reset_idle: activity=%b expected 0", act);
      else n_pass++;
      ofifo_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_acc();
      preload(4'd2, row_fill(5)); preload(4'd3, row_fill(-3)); preload(4'd4, row_fill(7));
      repeat (3) fifo_q.push_back(row_fill(1));
      push_expected(MODE_ACC, 4'd2, 3);
      run_job(MODE_ACC, 4'd2, 5'd3, 1'b0);
      n_checks++;
      if (done_cyc !== 6) $display("FAIL acc_done_cycle: got %0d expected 6", done_cyc); else n_pass++;
      n_checks++;
      if (busy_err !== 0) $display("FAIL acc_busy: got %0d bad cycles expected 0", busy_err); else n_pass++;
      n_checks++;
      if (pops !== 3) $display("FAIL acc_pops: got %0d expected 3", pops); else n_pass++;
      n_checks++;
      if (mem[2] !== row_fill(6) || mem[3] !== row_fill(-2) || mem[4] !== row_fill(8))
         $display("FAIL acc_mem: got lane0 %0d %0d %0d expected 6 -2 8",
                  lane_of(mem[2], 0), lane_of(mem[3], 0), lane_of(mem[4], 0));
      else n_pass++;
      n_checks++;
      if (sb_q.size() !== 0) $display("FAIL acc_missing_writes: got %0d left expected 0", sb_q.size());
      else n_pass++;
      sb_q.delete();
   endtask

   task automatic test_sat();
      preload(4'd0, row_fill(PMAX)); preload(4'd1, row_fill(PMIN));
      fifo_q.push_back(row_fill(5)); fifo_q.push_back(row_fill(-1));
      push_expected(MODE_ACC, 4'd0, 2);
      run_job(MODE_ACC, 4'd0, 5'd2, 1'b0);
      n_checks++;
      if (mem[0] !== row_fill(32767) || mem[1] !== row_fill(-32768))
         $display("FAIL sat_clamp: got %0d %0d expected 32767 -32768", lane_of(mem[0], 3), lane_of(mem[1], 3));
      else n_pass++;
      n_checks++;
      if (memw[0] !== row_fill(-32764) || memw[1] !== row_fill(32767))
         $display("FAIL sat_wrap: got %0d %0d expected -32764 32767", lane_of(memw[0], 3), lane_of(memw[1], 3));
      else n_pass++;
      n_checks++;
      if (done_cyc !== 5) $display("FAIL sat_done_cycle: got %0d expected 5", done_cyc); else n_pass++;
      sb_q.delete();
   endtask

   task automatic test_relu_wrap();
      preload(4'd14, row_fill(-9)); preload(4'd15, row_fill(0));
      preload(4'd0, row_fill(12));  preload(4'd1, row_ramp(-4, 1));
      fifo_q.push_back(row_fill(99));
      push_expected(MODE_RELU, 4'd14, 4);
      run_job(MODE_RELU, 4'd14, 5'd4, 1'b0);
      n_checks++;
      if (pops !== 0) $display("FAIL relu_no_pop: got %0d pops expected 0", pops); else n_pass++;
      n_checks++;
      if (rds !== 4) $display("FAIL relu_reads: got %0d expected 4", rds); else n_pass++;
      n_checks++;
      if (done_cyc !== 7) $display("FAIL relu_done_cycle: got %0d expected 7", done_cyc); else n_pass++;
      n_checks++;
      if (mem[14] !== '0 || mem[15] !== '0 || mem[0] !== row_fill(12))
         $display("FAIL relu_mem: got %0d %0d %0d expected 0 0 12",
                  lane_of(mem[14], 0), lane_of(mem[15], 0), lane_of(mem[0], 0));
      else n_pass++;
      n_checks++;
      if (lane_of(mem[1], 0) !== 0 || lane_of(mem[1], 7) !== 3)
         $display("FAIL relu_mixed: got %0d %0d expected 0 3", lane_of(mem[1], 0), lane_of(mem[1], 7));
      else n_pass++;
      fifo_q.delete(); sb_q.delete();
   endtask

   task automatic test_back_pressure();
      for (int k = 0; k < 4; k++) fifo_q.push_back(row_ramp(100 * (k + 1), 3));
      push_expected(MODE_LOAD, 4'd5, 4);
      run_job(MODE_LOAD, 4'd5, 5'd4, 1'b1);
      n_checks++;
      if (pops !== 4 || wrs !== 4) $display("FAIL bp_counts: got pops=%0d wrs=%0d expected 4 4", pops, wrs);
      else n_pass++;
      n_checks++;
      if (rds !== 0) $display("FAIL bp_no_read: got %0d reads expected 0", rds); else n_pass++;
      n_checks++;
      if (order_err !== 0) $display("FAIL bp_write_before_pop: got %0d expected 0", order_err); else n_pass++;
      n_checks++;
      if (done_cyc !== last_wr + 1 || last_wr < 0)
         $display("FAIL bp_done_after_write: got done=%0d expected %0d", done_cyc, last_wr + 1);
      else n_pass++;
      n_checks++;
      if (mem[8] !== row_ramp(400, 3)) $display("FAIL bp_last_row: got %h expected %h", mem[8], row_ramp(400, 3));
      else n_pass++;
      fifo_q.delete(); sb_q.delete();
   endtask

   task automatic test_abort_restart();
      logic act;
      logic issued2;
      preload(4'd8, row_fill(10)); preload(4'd9, row_fill(20));
      start = 1'b1; mode = MODE_ACC; base_addr = 4'd8; len = 5'd4;
      ofifo_valid = 1'b1; ofifo_out = row_fill(1);
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); issued2 = ofifo_rd;
      @(posedge clk); #1; reset_n = 1'b0;
      act = 1'b0;
      repeat (4) begin
         @(negedge clk);
         act = act | busy | done | ofifo_rd | psum_mem_rd | psum_mem_wr;
      end
      n_checks++;
      if (issued2 !== 1'b1 || act !== 1'b0)
         $display("FAIL abort_quiet: got issued2=%b activity=%b expected 1 0", issued2, act);
      else n_pass++;
      n_checks++;
      if (mem[8] !== row_fill(10) || mem[9] !== row_fill(20))
         $display("FAIL abort_mem: got %0d %0d expected 10 20", lane_of(mem[8], 0), lane_of(mem[9], 0));
      else n_pass++;
      @(posedge clk); #1;
      reset_n = 1'b1; ofifo_valid = 1'b0;
      @(posedge clk); #1;
      fifo_q.delete(); sb_q.delete();
      repeat (2) fifo_q.push_back(row_fill(1));
      push_expected(MODE_ACC, 4'd8, 2);
      run_job(MODE_ACC, 4'd8, 5'd2, 1'b0);
      n_checks++;
      if (done_cyc !== 5 || mem[8] !== row_fill(11) || mem[9] !== row_fill(21))
         $display("FAIL restart: got done=%0d rows %0d %0d expected 5 11 21",
                  done_cyc, lane_of(mem[8], 0), lane_of(mem[9], 0));
      else n_pass++;
      // Back-to-back: the previous run_job leaves us in the cycle after done.
      run_job(MODE_ACC, 4'd3, 5'd0, 1'b0);
      n_checks++;
      if (done_cyc !== 1 || rds !== 0 || wrs !== 0 || pops !== 0 || busy_err !== 0)
         $display("FAIL len0: got done=%0d rd=%0d wr=%0d pop=%0d busy_err=%0d expected 1 0 0 0 0",
                  done_cyc, rds, wrs, pops, busy_err);
      else n_pass++;
      fifo_q.push_back(row_fill(1));
      run_job(MODE_NOP, 4'd3, 5'd2, 1'b0);
      n_checks++;
      if (done_cyc !== 1 || rds !== 0 || wrs !== 0 || pops !== 0)
         $display("FAIL nop: got done=%0d rd=%0d wr=%0d pop=%0d expected 1 0 0 0", done_cyc, rds, wrs, pops);
      else n_pass++;
      fifo_q.delete(); sb_q.delete();
   endtask

   initial begin
      test_reset();
      test_acc();
      test_sat();
      test_relu_wrap();
      test_back_pressure();
      test_abort_restart();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
